regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 177 +++++++++++++++++
 tb/tb_regfile_sb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- register file with byte-enabled writeback and a busy-bit
// scoreboard for in-flight destination registers.
//
// Register 0 is hard-wired: it reads as zero, is never busy, and ignores
// writebacks and issues. Registers 1..2**ADDR_W-1 hold data.
//
// Ports
//   Clk                   rising-edge clock
//   Reset                 asynchronous, active-high reset (clears data, busy, count)
//   R_Addr_A / R_Addr_B   read addresses
//   R_Data_A / R_Data_B   combinational read data (optionally forwarded from writeback)
//   Busy_A / Busy_B       registered busy bit of the addressed register
//   Write_Reg             writeback strobe
//   W_Addr / W_Data       writeback address and data
//   W_BE                  byte enables, bit k covers W_Data[8k+7:8k]
//   Issue_Valid           request to reserve Issue_Addr as a destination
//   Issue_Addr            destination register being reserved
//   Issue_Ready           issue accepted this cycle (combinational)
//   Pending_Cnt           number of busy registers (registered)
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_W-1:0]     R_Addr_A,
    input  logic [ADDR_W-1:0]     R_Addr_B,
    output logic [DATA_W-1:0]     R_Data_A,
    output logic [DATA_W-1:0]     R_Data_B,
    output logic                  Busy_A,
    output logic                  Busy_B,
    input  logic                  Write_Reg,
    input  logic [ADDR_W-1:0]     W_Addr,
    input  logic [DATA_W-1:0]     W_Data,
    input  logic [DATA_W/8-1:0]   W_BE,
    input  logic                  Issue_Valid,
    input  logic [ADDR_W-1:0]     Issue_Addr,
    output logic                  Issue_Ready,
    output logic [ADDR_W:0]       Pending_Cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    // Replace the bytes of old_d selected by be with the matching bytes of new_d.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_d,
        input logic [DATA_W-1:0] new_d,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_d;
        for (int k = 0; k < BE_W; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_d[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_d[8*k +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              wr_en_s;
    logic              set_s;
    logic              inc_s;
    logic              dec_s;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [DATA_W-1:0] stored_a_s;
    logic [DATA_W-1:0] stored_b_s;
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    // Writes to register 0 are dropped, so the strobe is qualified here once.
    assign wr_en_s = Write_Reg && (W_Addr != ADDR_ZERO);

    // A writeback to the same register frees it in this cycle, so the issue may proceed.
    assign Issue_Ready = Issue_Valid &&
                         ((Issue_Addr == ADDR_ZERO) || !busy_r[Issue_Addr] ||
                          (Write_Reg && (W_Addr == Issue_Addr)));

    assign set_s = Issue_Ready && (Issue_Addr != ADDR_ZERO);

    // Count moves only on real bit transitions; a same-address set+clear keeps the bit set.
    assign inc_s = set_s && !busy_r[Issue_Addr];
    assign dec_s = wr_en_s && busy_r[W_Addr] && !(set_s && (Issue_Addr == W_Addr));

    assign stored_a_s = (R_Addr_A == ADDR_ZERO) ? DATA_ZERO : mem_r[R_Addr_A];
    assign stored_b_s = (R_Addr_B == ADDR_ZERO) ? DATA_ZERO : mem_r[R_Addr_B];

    // Read port A with optional same-cycle forwarding of the merged writeback.
    always_comb begin
        rd_a_s = stored_a_s;
        if ((BYPASS == 1) && wr_en_s && (W_Addr == R_Addr_A)) begin
            rd_a_s = byte_merge(stored_a_s, W_Data, W_BE);
        end else begin
            rd_a_s = stored_a_s;
        end
    end

    // Read port B with optional same-cycle forwarding of the merged writeback.
    always_comb begin
        rd_b_s = stored_b_s;
        if ((BYPASS == 1) && wr_en_s && (W_Addr == R_Addr_B)) begin
            rd_b_s = byte_merge(stored_b_s, W_Data, W_BE);
        end else begin
            rd_b_s = stored_b_s;
        end
    end

    assign R_Data_A    = rd_a_s;
    assign R_Data_B    = rd_b_s;
    assign Busy_A      = busy_r[R_Addr_A];
    assign Busy_B      = busy_r[R_Addr_B];
    assign Pending_Cnt = cnt_r;

    // Next busy vector: clear on writeback first, then set on issue so that set wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (wr_en_s) begin
            busy_nxt_s[W_Addr] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (set_s) begin
            busy_nxt_s[Issue_Addr] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Next pending count from the set/clear transition pair.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({inc_s, dec_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
            2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Register storage with byte-enabled writeback.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DATA_ZERO;
            end
        end else if (wr_en_s) begin
            mem_r[W_Addr] <= byte_merge(mem_r[W_Addr], W_Data, W_BE);
        end
    end

    // Scoreboard busy bits and pending count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_r <= {DEPTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          Clk;
    logic          Reset;
    logic [AW-1:0] R_Addr_A, R_Addr_B, W_Addr, Issue_Addr;
    logic [DW-1:0] W_Data;
    logic [3:0]    W_BE;
    logic          Write_Reg, Issue_Valid;

    logic [DW-1:0] byp_rd_a, byp_rd_b, nob_rd_a, nob_rd_b;
    logic          byp_busy_a, byp_busy_b, nob_busy_a, nob_busy_b;
    logic          byp_rdy, nob_rdy;
    logic [AW:0]   byp_cnt, nob_cnt;

    int total;
    int bad;

    // reference model state
    logic [DW-1:0] mem_m [NR];
    bit            busy_m [NR];

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) u_byp (
        .Clk(Clk), .Reset(Reset),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
        .R_Data_A(byp_rd_a), .R_Data_B(byp_rd_b),
        .Busy_A(byp_busy_a), .Busy_B(byp_busy_b),
        .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data), .W_BE(W_BE),
        .Issue_Valid(Issue_Valid), .Issue_Addr(Issue_Addr),
        .Issue_Ready(byp_rdy), .Pending_Cnt(byp_cnt)
    );

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) u_nob (
        .Clk(Clk), .Reset(Reset),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
        .R_Data_A(nob_rd_a), .R_Data_B(nob_rd_b),
        .Busy_A(nob_busy_a), .Busy_B(nob_busy_b),
        .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data), .W_BE(W_BE),
        .Issue_Valid(Issue_Valid), .Issue_Addr(Issue_Addr),
        .Issue_Ready(nob_rdy), .Pending_Cnt(nob_cnt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) begin
            mem_m[i]  = '0;
            busy_m[i] = 0;
        end
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [3:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && Write_Reg && W_Addr == a) return merge(mem_m[a], W_Data, W_BE);
        return mem_m[a];
    endfunction

    function automatic bit exp_rdy();
        return Issue_Valid && (Issue_Addr == 0 || !busy_m[Issue_Addr] ||
                               (Write_Reg && W_Addr == Issue_Addr));
    endfunction

    function automatic int popcnt();
        int c;
        c = 0;
        for (int i = 0; i < NR; i++) c += busy_m[i];
        return c;
    endfunction

    task automatic idle();
        Write_Reg = 1'b0; W_Addr = '0; W_Data = '0; W_BE = '0;
        Issue_Valid = 1'b0; Issue_Addr = '0;
    endtask

    // one rising edge; the model follows the rules with the inputs held across the edge
    task automatic tick();
        bit rdy;
        rdy = exp_rdy();
        @(posedge Clk);
        if (Reset) begin
            model_clear();
        end else begin
            if (Write_Reg && W_Addr != 0) begin
                mem_m[W_Addr]  = merge(mem_m[W_Addr], W_Data, W_BE);
                busy_m[W_Addr] = 0;
            end
            if (rdy && Issue_Addr != 0) busy_m[Issue_Addr] = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; idle(); R_Addr_A = 5'd5; R_Addr_B = 5'd31;
        model_clear();
        #3;
        total++; if (byp_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", byp_cnt); end
        total++; if (byp_rd_a !== 32'h0 || byp_rd_b !== 32'h0) begin bad++; $display("FAIL reset_rd: got %h/%h want 0", byp_rd_a, byp_rd_b); end
        total++; if (byp_busy_a !== 1'b0 || nob_busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b/%b want 0", byp_busy_a, nob_busy_b); end
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_write_read();
        idle(); Write_Reg = 1'b1; W_Addr = 5'd5; W_Data = 32'hDEADBEEF; W_BE = 4'hF;
        tick();
        idle(); R_Addr_A = 5'd5; #1;
        total++; if (byp_rd_a !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_r5: got %h want deadbeef", byp_rd_a); end
        total++; if (nob_rd_a !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_r5_nob: got %h want deadbeef", nob_rd_a); end
        Write_Reg = 1'b1; W_Addr = 5'd0; W_Data = 32'h1234; W_BE = 4'hF; R_Addr_B = 5'd0; #1;
        total++; if (byp_rd_b !== 32'h0) begin bad++; $display("FAIL r0_bypass: got %h want 0", byp_rd_b); end
        tick();
        idle(); R_Addr_B = 5'd0; #1;
        total++; if (byp_rd_b !== 32'h0 || nob_rd_b !== 32'h0) begin bad++; $display("FAIL r0_read: got %h/%h want 0", byp_rd_b, nob_rd_b); end
    endtask

    task automatic test_byte_bypass();
        idle(); Write_Reg = 1'b1; W_Addr = 5'd7; W_Data = 32'h11223344; W_BE = 4'hF;
        tick();
        W_Data = 32'hAABBCCDD; W_BE = 4'b0101; R_Addr_A = 5'd7; #1;
        total++; if (byp_rd_a !== 32'h11BB33DD) begin bad++; $display("FAIL be_bypass: got %h want 11bb33dd", byp_rd_a); end
        total++; if (nob_rd_a !== 32'h11223344) begin bad++; $display("FAIL be_nobypass: got %h want 11223344", nob_rd_a); end
        tick();
        idle(); R_Addr_A = 5'd7; #1;
        total++; if (byp_rd_a !== 32'h11BB33DD || nob_rd_a !== 32'h11BB33DD) begin bad++; $display("FAIL be_after: got %h/%h want 11bb33dd", byp_rd_a, nob_rd_a); end
        W_Addr = 5'd7; W_BE = 4'h0; W_Data = 32'hFFFFFFFF; Write_Reg = 1'b1;
        tick();
        idle(); R_Addr_A = 5'd7; #1;
        total++; if (byp_rd_a !== 32'h11BB33DD) begin bad++; $display("FAIL be_zero: got %h want 11bb33dd", byp_rd_a); end
    endtask

    task automatic test_scoreboard();
        idle(); Issue_Valid = 1'b1; Issue_Addr = 5'd3; #1;
        total++; if (byp_rdy !== 1'b1) begin bad++; $display("FAIL sb_issue_rdy: got %b want 1", byp_rdy); end
        tick();
        idle(); R_Addr_A = 5'd3; #1;
        total++; if (byp_busy_a !== 1'b1 || byp_cnt !== 6'd1) begin bad++; $display("FAIL sb_set: got busy=%b cnt=%0d want 1/1", byp_busy_a, byp_cnt); end
        Issue_Valid = 1'b1; Issue_Addr = 5'd3; #1;
        total++; if (byp_rdy !== 1'b0) begin bad++; $display("FAIL sb_reissue: got %b want 0", byp_rdy); end
        tick();
        total++; if (byp_cnt !== 6'd1) begin bad++; $display("FAIL sb_reissue_cnt: got %0d want 1", byp_cnt); end
        idle(); Write_Reg = 1'b1; W_Addr = 5'd3; W_Data = 32'h5; W_BE = 4'h1; R_Addr_A = 5'd3;
        tick();
        idle(); R_Addr_A = 5'd3; #1;
        total++; if (byp_busy_a !== 1'b0 || byp_cnt !== 6'd0) begin bad++; $display("FAIL sb_clear: got busy=%b cnt=%0d want 0/0", byp_busy_a, byp_cnt); end
    endtask

    task automatic test_set_wins();
        idle(); Issue_Valid = 1'b1; Issue_Addr = 5'd9;
        tick();
        idle(); Write_Reg = 1'b1; W_Addr = 5'd9; W_Data = 32'h99; W_BE = 4'hF;
        Issue_Valid = 1'b1; Issue_Addr = 5'd9; R_Addr_B = 5'd9; #1;
        total++; if (byp_rdy !== 1'b1) begin bad++; $display("FAIL setwin_rdy: got %b want 1", byp_rdy); end
        total++; if (byp_busy_b !== 1'b1) begin bad++; $display("FAIL setwin_busy_pre: got %b want 1", byp_busy_b); end
        tick();
        idle(); R_Addr_B = 5'd9; #1;
        total++; if (byp_busy_b !== 1'b1 || byp_cnt !== 6'd1) begin bad++; $display("FAIL setwin_after: got busy=%b cnt=%0d want 1/1", byp_busy_b, byp_cnt); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            Write_Reg   = 1'($urandom_range(0, 1));
            W_Addr      = 5'($urandom_range(0, NR - 1));
            W_Data      = $urandom;
            W_BE        = 4'($urandom_range(0, 15));
            Issue_Valid = 1'($urandom_range(0, 1));
            Issue_Addr  = ($urandom_range(0, 3) == 0) ? W_Addr : 5'($urandom_range(0, NR - 1));
            R_Addr_A    = ($urandom_range(0, 2) == 0) ? W_Addr : 5'($urandom_range(0, NR - 1));
            R_Addr_B    = ($urandom_range(0, 2) == 0) ? Issue_Addr : 5'($urandom_range(0, NR - 1));
            #1;
            total++; if (byp_rdy !== exp_rdy() || nob_rdy !== exp_rdy()) begin bad++; $display("FAIL rnd_rdy %0d: got %b/%b want %b", n, byp_rdy, nob_rdy, exp_rdy()); end
            total++; if (byp_rd_a !== exp_rd(R_Addr_A, 1) || byp_rd_b !== exp_rd(R_Addr_B, 1)) begin bad++; $display("FAIL rnd_rd_byp %0d: got %h/%h want %h/%h", n, byp_rd_a, byp_rd_b, exp_rd(R_Addr_A, 1), exp_rd(R_Addr_B, 1)); end
            total++; if (nob_rd_a !== exp_rd(R_Addr_A, 0) || nob_rd_b !== exp_rd(R_Addr_B, 0)) begin bad++; $display("FAIL rnd_rd_nob %0d: got %h/%h want %h/%h", n, nob_rd_a, nob_rd_b, exp_rd(R_Addr_A, 0), exp_rd(R_Addr_B, 0)); end
            total++; if (byp_busy_a !== busy_m[R_Addr_A] || byp_busy_b !== busy_m[R_Addr_B]) begin bad++; $display("FAIL rnd_busy %0d: got %b/%b want %b/%b", n, byp_busy_a, byp_busy_b, busy_m[R_Addr_A], busy_m[R_Addr_B]); end
            total++; if (int'(byp_cnt) != popcnt() || int'(nob_cnt) != popcnt()) begin bad++; $display("FAIL rnd_cnt %0d: got %0d/%0d want %0d", n, byp_cnt, nob_cnt, popcnt()); end
            tick();
        end
    endtask

    task automatic test_fill_reset();
        int errs;
        Reset = 1'b1; idle(); #1; model_clear(); Reset = 1'b0;
        for (int a = 1; a < NR; a++) begin
            Issue_Valid = 1'b1; Issue_Addr = 5'(a);
            tick();
        end
        idle();
        Write_Reg = 1'b1; W_Addr = 5'd12; W_Data = 32'hCAFEF00D; W_BE = 4'hF;
        tick();
        idle(); Issue_Valid = 1'b1; Issue_Addr = 5'd12;
        tick();
        idle(); #1;
        total++; if (byp_cnt !== 6'd31 || nob_cnt !== 6'd31) begin bad++; $display("FAIL fill_cnt: got %0d/%0d want 31", byp_cnt, nob_cnt); end
        #2 Reset = 1'b1;
        model_clear();
        #1;
        total++; if (byp_cnt !== 6'd0) begin bad++; $display("FAIL midreset_cnt: got %0d want 0", byp_cnt); end
        errs = 0;
        for (int a = 0; a < NR; a++) begin
            R_Addr_A = 5'(a); R_Addr_B = 5'(NR - 1 - a); #1;
            if (byp_rd_a !== 32'h0 || nob_rd_b !== 32'h0 || byp_busy_a !== 1'b0 || nob_busy_b !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL midreset_all: got %0d nonzero entries want 0", errs); end
        // strobes during reset must be ignored
        @(negedge Clk);
        Write_Reg = 1'b1; W_Addr = 5'd4; W_Data = 32'h44444444; W_BE = 4'hF;
        Issue_Valid = 1'b1; Issue_Addr = 5'd6; R_Addr_A = 5'd6; #1;
        total++; if (byp_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy_comb: got %b want 1", byp_rdy); end
        tick();
        idle(); R_Addr_A = 5'd6; R_Addr_B = 5'd4; #1;
        total++; if (byp_busy_a !== 1'b0 || byp_cnt !== 6'd0 || nob_rd_b !== 32'h0) begin bad++; $display("FAIL reset_ignore: got busy=%b cnt=%0d rd=%h want 0/0/0", byp_busy_a, byp_cnt, nob_rd_b); end
        Reset = 1'b0;
        Write_Reg = 1'b1; W_Addr = 5'd4; W_Data = 32'h01020304; W_BE = 4'hF;
        tick();
        idle(); R_Addr_B = 5'd4; #1;
        total++; if (nob_rd_b !== 32'h01020304) begin bad++; $display("FAIL resume: got %h want 01020304", nob_rd_b); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_byte_bypass();
        test_scoreboard();
        test_set_wins();
        test_random();
        test_fill_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
